// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and the operand-stage opcode enumeration.
package alu_pkg;

    localparam int ALU_OP_WIDTH = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_RSUB = 3'b010,
        OP_NEG  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_PASS = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Handshake bundle of the ALU operand stage: raw op in, conditioned adder operands out.
interface alu_operand_stage_if
    import alu_pkg::*;
#(
    parameter int SRC_WIDTH = 32,
    parameter int TAG_WIDTH = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ALU_OP_WIDTH-1:0] in_op;
    logic [SRC_WIDTH-1:0]    in_src1;
    logic [SRC_WIDTH-1:0]    in_src2;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [SRC_WIDTH-1:0]    out_src1;
    logic [SRC_WIDTH-1:0]    out_src2;
    logic                    out_cin;
    logic [TAG_WIDTH-1:0]    out_tag;
    logic                    out_illegal;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_src1, out_src2, out_cin, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_src1, out_src2, out_cin, out_tag, out_illegal
    );
endinterface

// File: rtl/alu_op_cond.sv
// Maps an ALU op and raw operands to the (src1, src2, cin) triple so that src1 + src2 + cin
// equals the requested result; reserved encodings behave as ADD and raise illegal.
module alu_op_cond
    import alu_pkg::*;
#(
    parameter int SRC_WIDTH = 32
) (
    input  alu_op_e              i_op,
    input  logic [SRC_WIDTH-1:0] i_src1,
    input  logic [SRC_WIDTH-1:0] i_src2,
    output logic [SRC_WIDTH-1:0] o_src1,
    output logic [SRC_WIDTH-1:0] o_src2,
    output logic                 o_cin,
    output logic                 o_illegal
);

    // Opcode decode into adder operands; subtraction uses invert-plus-carry.
    always_comb begin
        o_src1    = i_src1;
        o_src2    = i_src2;
        o_cin     = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  begin o_src1 = i_src1;         o_src2 = i_src2;          o_cin = 1'b0; end
            OP_SUB:  begin o_src1 = i_src1;         o_src2 = ~i_src2;         o_cin = 1'b1; end
            OP_RSUB: begin o_src1 = i_src2;         o_src2 = ~i_src1;         o_cin = 1'b1; end
            OP_NEG:  begin o_src1 = {SRC_WIDTH{1'b0}}; o_src2 = ~i_src1;      o_cin = 1'b1; end
            OP_INC:  begin o_src1 = i_src1;         o_src2 = {SRC_WIDTH{1'b0}}; o_cin = 1'b1; end
            OP_DEC:  begin o_src1 = i_src1;         o_src2 = {SRC_WIDTH{1'b1}}; o_cin = 1'b0; end
            OP_PASS: begin o_src1 = i_src1;         o_src2 = {SRC_WIDTH{1'b0}}; o_cin = 1'b0; end
            OP_RSVD: begin o_illegal = 1'b1; end
            default: begin o_illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand-conditioning stage with a two-entry skid buffer ahead of the ALU adder.
// Define ALU_OPSTAGE_PERF_EN to add the issue/stall performance counters.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int SRC_WIDTH = 32,
    parameter int TAG_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  io_bus
`ifdef ALU_OPSTAGE_PERF_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_main_load;
    logic                 w_skid_valid_nxt;
    logic [SRC_WIDTH-1:0] w_c_src1;
    logic [SRC_WIDTH-1:0] w_c_src2;
    logic                 w_c_cin;
    logic                 w_c_illegal;

    logic                 r_in_ready;
    logic                 r_main_valid;
    logic [SRC_WIDTH-1:0] r_main_src1;
    logic [SRC_WIDTH-1:0] r_main_src2;
    logic                 r_main_cin;
    logic                 r_main_illegal;
    logic [TAG_WIDTH-1:0] r_main_tag;
    logic                 r_skid_valid;
    logic [SRC_WIDTH-1:0] r_skid_src1;
    logic [SRC_WIDTH-1:0] r_skid_src2;
    logic                 r_skid_cin;
    logic                 r_skid_illegal;
    logic [TAG_WIDTH-1:0] r_skid_tag;

    alu_op_cond #(.SRC_WIDTH(SRC_WIDTH)) u_cond (
        .i_op      (alu_op_e'(io_bus.in_op)),
        .i_src1    (io_bus.in_src1),
        .i_src2    (io_bus.in_src2),
        .o_src1    (w_c_src1),
        .o_src2    (w_c_src2),
        .o_cin     (w_c_cin),
        .o_illegal (w_c_illegal)
    );

    // Handshake qualification and next skid occupancy.
    always_comb begin
        w_in_fire   = io_bus.in_valid && r_in_ready;
        w_out_fire  = r_main_valid && io_bus.out_ready;
        w_main_load = !r_main_valid || w_out_fire;
        if (w_main_load) begin
            w_skid_valid_nxt = 1'b0;
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
        end else begin
            w_skid_valid_nxt = r_skid_valid;
        end
    end

    // Main/skid storage; skid always drains into main before new input so order stays FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready     <= 1'b1;
            r_main_valid   <= 1'b0;
            r_main_src1    <= {SRC_WIDTH{1'b0}};
            r_main_src2    <= {SRC_WIDTH{1'b0}};
            r_main_cin     <= 1'b0;
            r_main_illegal <= 1'b0;
            r_main_tag     <= {TAG_WIDTH{1'b0}};
            r_skid_valid   <= 1'b0;
            r_skid_src1    <= {SRC_WIDTH{1'b0}};
            r_skid_src2    <= {SRC_WIDTH{1'b0}};
            r_skid_cin     <= 1'b0;
            r_skid_illegal <= 1'b0;
            r_skid_tag     <= {TAG_WIDTH{1'b0}};
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_main_load) begin
                if (r_skid_valid) begin
                    r_main_valid   <= 1'b1;
                    r_main_src1    <= r_skid_src1;
                    r_main_src2    <= r_skid_src2;
                    r_main_cin     <= r_skid_cin;
                    r_main_illegal <= r_skid_illegal;
                    r_main_tag     <= r_skid_tag;
                end else if (w_in_fire) begin
                    r_main_valid   <= 1'b1;
                    r_main_src1    <= w_c_src1;
                    r_main_src2    <= w_c_src2;
                    r_main_cin     <= w_c_cin;
                    r_main_illegal <= w_c_illegal;
                    r_main_tag     <= io_bus.in_tag;
                end else begin
                    r_main_valid   <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_src1    <= w_c_src1;
                r_skid_src2    <= w_c_src2;
                r_skid_cin     <= w_c_cin;
                r_skid_illegal <= w_c_illegal;
                r_skid_tag     <= io_bus.in_tag;
            end
        end
    end

    assign io_bus.in_ready    = r_in_ready;
    assign io_bus.out_valid   = r_main_valid;
    assign io_bus.out_src1    = r_main_src1;
    assign io_bus.out_src2    = r_main_src2;
    assign io_bus.out_cin     = r_main_cin;
    assign io_bus.out_illegal = r_main_illegal;
    assign io_bus.out_tag     = r_main_tag;

`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;

    // Issue and back-pressure counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_out_fire) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (r_main_valid && !io_bus.out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_issue_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-conditioning stage placed directly upstream of the ALU adder. Accepts an arithmetic op plus two raw operands over a valid/ready handshake, then produces the exact `src1`/`src2`/`cin` triple the adder consumes, so that `out = src1 + src2 + cin` yields the requested result. A two-entry skid buffer gives full throughput with a registered `in_ready`, and isolates the register-read timing from adder timing.

## Interface
- `SRC_WIDTH`, 32, operand width; equals the adder's `SRC_WIDTH`.
- `TAG_WIDTH`, 6, sideband tag (destination/thread id), carried unmodified.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents an op.
- `in_ready`  out  1  stage can accept; registered.
- `in_op`  in  3  opcode (see Operation).
- `in_src1`, `in_src2`  in  SRC_WIDTH  raw operands.
- `in_tag`  in  TAG_WIDTH  sideband.
- `out_valid`  out  1  conditioned operands valid.
- `out_ready`  in  1  downstream (adder/writeback) accepts.
- `out_src1`, `out_src2`  out  SRC_WIDTH  adder inputs.
- `out_cin`  out  1  adder carry-in.
- `out_tag`  out  TAG_WIDTH  sideband.
- `out_illegal`  out  1  op was reserved encoding.
- `perf_issue_cnt`, `perf_stall_cnt`  out  32  present only with `ALU_OPSTAGE_PERF_EN`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Op map (src1', src2', cin):
  - 000 ADD: a, b, 0
  - 001 SUB: a, ~b, 1 (a−b)
  - 010 RSUB: b, ~a, 1 (b−a)
  - 011 NEG: 0, ~a, 1 (−a)
  - 100 INC: a, 0, 1
  - 101 DEC: a, all-ones, 0
  - 110 PASS: a, 0, 0
  - 111 reserved: treated as ADD, `out_illegal`=1.
- Conditioning is combinational on input and stored already conditioned; outputs come straight from the main register.
- Storage: main register (drives outputs) and skid register.
  - Main empty, or main leaving this cycle: the input (or the skid entry, if full) loads into main.
  - Main full and not leaving, with input accepted: the input goes to skid.
  - Skid drains into main before any new input; order is strictly FIFO.
- `in_ready` = !skid_valid (registered). Input is never dropped; skid never overflows.
- `out_*` data stable while `out_valid && !out_ready`.
- Width: all operand logic is SRC_WIDTH bits, two's-complement wrap; no carry-out is produced here.

## Timing
- Latency 1 cycle: an input accepted at edge N is visible on `out_*` after edge N.
- Throughput 1 op/cycle while `out_ready`=1.
- `out_ready` low for k cycles: at most 2 ops buffered; `in_ready` drops the cycle after skid fills and rises the cycle after skid drains.
- Simultaneous in/out transfer with main full and skid empty: main reloads with the new op; skid stays empty.
- Reset (any time, including mid-stall): `out_valid`=0, `in_ready`=1 (after reset deasserts), all data/tag/cin/illegal outputs 0, skid empty, perf counters 0. In-flight ops are discarded.

## Configuration
- `ALU_OPSTAGE_PERF_EN` defined:
  - `perf_issue_cnt` increments on each output transfer.
  - `perf_stall_cnt` increments each cycle with `out_valid && !out_ready`.
  - Both wrap at 2^32.
- Undefined: counter ports and logic absent; all other behaviour identical.

## Structure
- Shared `alu_pkg`: `alu_op_e` enum (7 ops plus reserved), and `ALU_OP_WIDTH`=3.
- One sub-module `alu_op_cond`: combinational op → (src1', src2', cin, illegal) mapping, instanced once ahead of the buffer.
- The skid buffer stays inline.

## Test plan
- ADD 5+7, `out_ready`=1 -> next cycle out_src1=5, out_src2=7, cin=0; feeding the adder gives 12.
- SUB 3−5 then RSUB a=3, b=5 (32-bit) -> adder results 0xFFFFFFFE and 0x00000002; NEG a=1 -> 0xFFFFFFFF; DEC 0 -> 0xFFFFFFFF.
- Op 111 with a=1, b=2 -> out_illegal=1, adder sum 3.
- Stream of 4 ops with `out_ready` low for 3 cycles -> 2 accepted, `in_ready`=0 after skid fills; on release all 4 emerge in order, none lost or duplicated.
- Assert `rst` while 2 ops are buffered -> out_valid=0 immediately; after release in_ready=1; old ops never appear.
- With `ALU_OPSTAGE_PERF_EN`: 10 transfers and 4 stall cycles -> perf_issue_cnt=10, perf_stall_cnt=4.
